// File: rtl/kpg_add_seq.sv
// rtl/kpg_add_seq.sv - sequential 16-bit adder using a shared kill/propagate/generate prefix stage
module kpg_add_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Number of prefix levels needed to resolve every carry across WIDTH bits.
    localparam int LEVELS = $clog2(WIDTH);

    // Per-bit carry status: kill=00, propagate=01 (10 also reads as propagate), generate=11.
    localparam logic [1:0] KPG_K = 2'b00;
    localparam logic [1:0] KPG_P = 2'b01;
    localparam logic [1:0] KPG_G = 2'b11;

    typedef logic [WIDTH-1:0][1:0] kpg_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEVEL = 2'd1,
        SUM   = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [1:0]       lvl, lvl_d;
    kpg_t             kpg, kpg_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             cin_q, cin_d;
    logic             busy_d, done_d, cout_d;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] carry;

    // Initial per-bit classification, with cin folded into bit 0 so the
    // prefix network alone decides every carry.
    function automatic kpg_t kpg_load(input logic [WIDTH-1:0] x,
                                      input logic [WIDTH-1:0] y,
                                      input logic             ci);
        kpg_t r;
        for (int i = 0; i < WIDTH; i++) begin
            case ({x[i], y[i]})
                2'b00:   r[i] = KPG_K;
                2'b11:   r[i] = KPG_G;
                default: r[i] = KPG_P;
            endcase
        end
        if (r[0] == KPG_P) begin
            r[0] = ci ? KPG_G : KPG_K;
        end
        return r;
    endfunction

    // One Kogge-Stone style level at distance 1<<l; reads only the incoming
    // vector so there is no chaining within a level.
    function automatic kpg_t kpg_combine(input kpg_t k, input logic [1:0] l);
        kpg_t r;
        int   d;
        d = 1 << l;
        for (int i = 0; i < WIDTH; i++) begin
            if ((i >= d) && (k[i][1] != k[i][0])) begin
                r[i] = k[i - d];
            end else begin
                r[i] = k[i];
            end
        end
        return r;
    endfunction

    // Carry into each bit once the prefix has resolved every position to K or G.
    always_comb begin
        carry    = '0;
        carry[0] = cin_q;
        for (int i = 1; i < WIDTH; i++) begin
            carry[i] = (kpg[i - 1] == KPG_G);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and next-datapath decisions.
    always_comb begin
        state_d = state;
        lvl_d   = lvl;
        kpg_d   = kpg;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        busy_d  = busy;
        done_d  = 1'b0;
        sum_d   = sum;
        cout_d  = cout;
        case (state)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    cin_d   = cin;
                    kpg_d   = kpg_load(a, b, cin);
                    lvl_d   = 2'd0;
                    busy_d  = 1'b1;
                    state_d = LEVEL;
                end
            end
            LEVEL: begin
                kpg_d = kpg_combine(kpg, lvl);
                lvl_d = lvl + 2'd1;
                if (lvl == 2'(LEVELS - 1)) begin
                    state_d = SUM;
                end
            end
            SUM: begin
                sum_d   = a_q ^ b_q ^ carry;
                cout_d  = (kpg[WIDTH-1] == KPG_G);
                done_d  = 1'b1;
                busy_d  = 1'b0;
                lvl_d   = 2'd0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; reset clears everything, killing any op in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl   <= 2'd0;
            kpg   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            cin_q <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            lvl   <= lvl_d;
            kpg   <= kpg_d;
            a_q   <= a_d;
            b_q   <= b_d;
            cin_q <= cin_d;
            busy  <= busy_d;
            done  <= done_d;
            sum   <= sum_d;
            cout  <= cout_d;
        end
    end

endmodule

// File: tb/tb_kpg_add_seq.sv
// tb/tb_kpg_add_seq.sv - scoreboard bench for kpg_add_seq against a+b+cin
module tb_kpg_add_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc;
    int          n_pass;
    int          n_total;
    logic [15:0] last_sum;
    logic        last_cout;

    kpg_add_seq #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to time-stamp expected done cycles.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Reference: plain 17-bit addition, done six edges after the start edge.
    function automatic void push_exp(input logic [15:0] x, input logic [15:0] y,
                                     input logic ci, input int delay);
        exp_t        e;
        logic [16:0] r;
        r      = {1'b0, x} + {1'b0, y} + {16'b0, ci};
        e.sum  = r[15:0];
        e.cout = r[16];
        e.cyc  = cyc + delay;
        sb.push_back(e);
    endfunction

    // Monitor: pops on every done, flags lateness, and checks result hold between dones.
    always @(negedge clk) begin
        if (rst) begin
            last_sum  = 16'h0;
            last_cout = 1'b0;
        end else if (done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sum", 32'(sum), 32'(e.sum));
                chk("cout", 32'(cout), 32'(e.cout));
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
            last_sum  = sum;
            last_cout = cout;
        end else begin
            chk("sum_hold", 32'({cout, sum}), 32'({last_cout, last_sum}));
            if (sb.size() > 0 && cyc > sb[0].cyc) begin
                chk("done_timeout", 32'(cyc), 32'(sb[0].cyc));
                void'(sb.pop_front());
            end
        end
    end

    // One operation; leaves the bench in the done cycle so the next call starts back-to-back.
    task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic ci);
        a     = x;
        b     = y;
        cin   = ci;
        start = 1'b1;
        push_exp(x, y, ci, 6);
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
        cin   = 1'($urandom);
        chk("busy_after_start", 32'(busy), 32'd1);
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("busy_in_flight", 32'(busy), 32'd1);
        end
        @(posedge clk);
        #1;
        chk("busy_at_done", 32'(busy), 32'd0);
    endtask

    initial begin
        cyc     = 0;
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        start   = 1'b0;
        a       = 16'h0;
        b       = 16'h0;
        cin     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_sum", 32'({cout, sum}), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed vectors, including the full propagate chain.
        run_op(16'h1234, 16'h4321, 1'b0);
        run_op(16'hFFFF, 16'h0000, 1'b1);
        run_op(16'hFFFF, 16'h0000, 1'b0);
        run_op(16'h00FF, 16'h0001, 1'b0);
        run_op(16'h8000, 16'h8000, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 1'b1);

        // A second start two edges into an op must be ignored.
        a     = 16'hABCD;
        b     = 16'h1111;
        cin   = 1'b1;
        start = 1'b1;
        push_exp(16'hABCD, 16'h1111, 1'b1, 6);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        a     = 16'h0F0F;
        b     = 16'hF0F0;
        cin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("ignored_start_idle", 32'(busy), 32'd0);

        // Held start: four ops, one every six edges, identical results.
        a     = 16'h7FFF;
        b     = 16'h0001;
        cin   = 1'b1;
        start = 1'b1;
        for (int k = 1; k <= 4; k++) push_exp(16'h7FFF, 16'h0001, 1'b1, 6 * k);
        repeat (19) @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // Reset in the middle of an op: cleared at once, no done for it.
        run_op(16'h5A5A, 16'h0101, 1'b0);
        a     = 16'h2222;
        b     = 16'h3333;
        cin   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_op(16'h2222, 16'h3333, 1'b1);

        // Random regression.
        for (int n = 0; n < 10000; n++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom));
        end

        // Drain anything left, bounded.
        for (int w = 0; w < 20 && sb.size() > 0; w++) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
